clause_dispatch_ctrl: RTL and testbench

CLAUSE_DISPATCH_CTRL -- requirements
Module: clause_dispatch_ctrl

---
 rtl/clause_dispatch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_clause_dispatch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_dispatch_ctrl.sv
// Clause dispatch controller: reads clauses from memory and keeps an ordered window of them for the arbiter.
// Latency: mem_req one cycle after start; a returned clause is offered the cycle after its mem_valid edge.
// Backpressure: no new reads while window plus outstanding reads fill OUT_CNT; optional stall counter under CLAUSE_DISPATCH_STALL_CNT_EN.
module clause_dispatch_ctrl #(
    parameter int OUT_CNT  = 4,
    parameter int CLAUSE_W = 15,
    parameter int ADDR_W   = 16,
    localparam int CNT_W   = $clog2(OUT_CNT) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            base_addr,
    input  logic [ADDR_W-1:0]            num_clauses,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_valid,
    input  logic [CLAUSE_W-1:0]          mem_data,
    output logic [OUT_CNT*CLAUSE_W-1:0]  arb_clause,
    output logic [CNT_W-1:0]             arb_cnt,
    input  logic [CNT_W-1:0]             arb_accept,
    output logic                         busy,
    output logic                         done,
    output logic                         err
`ifdef CLAUSE_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   base_q, base_n, num_q, num_n;
    logic [ADDR_W-1:0]   issued_q, issued_n, retired_q, retired_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n, out_q, out_n, acc_eff;
    logic [CLAUSE_W-1:0] win_q [OUT_CNT];
    logic [CLAUSE_W-1:0] win_n [OUT_CNT];
    logic                err_n, mem_req_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    int                  acc_i, keep_i;

    // Next-state: window shift/append, read issue bookkeeping, FSM sequencing
    always_comb begin
        state_n   = state;
        base_n    = base_q;
        num_n     = num_q;
        issued_n  = issued_q;
        retired_n = retired_q;
        cnt_n     = cnt_q;
        out_n     = out_q;
        err_n     = err;
        win_n     = win_q;
        acc_eff   = '0;
        acc_i     = 0;
        keep_i    = 0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    base_n    = base_addr;
                    num_n     = num_clauses;
                    issued_n  = '0;
                    retired_n = '0;
                    cnt_n     = '0;
                    out_n     = '0;
                    err_n     = 1'b0;
                    state_n   = (num_clauses == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // An over-large accept is clamped to what is actually offered
                if (arb_accept > cnt_q) begin
                    acc_eff = cnt_q;
                    err_n   = 1'b1;
                end else begin
                    acc_eff = arb_accept;
                end
                acc_i  = int'(acc_eff);
                keep_i = int'(cnt_q) - acc_i;
                for (int i = 0; i < OUT_CNT; i++) begin
                    win_n[i] = '0;
                    for (int j = 0; j < OUT_CNT; j++) begin
                        if (i < keep_i && j == i + acc_i) begin
                            win_n[i] = win_q[j];
                        end
                    end
                end
                cnt_n = cnt_q - acc_eff;
                out_n = out_q + CNT_W'(mem_req);
                // The returning clause lands just behind the survivors of this cycle's accept
                if (mem_valid) begin
                    if (out_q != '0) begin
                        for (int i = 0; i < OUT_CNT; i++) begin
                            if (i == keep_i) begin
                                win_n[i] = mem_data;
                            end
                        end
                        cnt_n = cnt_n + CNT_W'(1);
                        out_n = out_n - CNT_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
                issued_n  = issued_q + ADDR_W'(mem_req);
                retired_n = retired_q + ADDR_W'(acc_eff);
                if (retired_n == num_q) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                    out_n   = '0;
                    for (int i = 0; i < OUT_CNT; i++) begin
                        win_n[i] = '0;
                    end
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // The request is decided on the values that will be current while it is presented
        mem_req_n  = (state_n == S_RUN) && (issued_n < num_n) &&
                     ((int'(cnt_n) + int'(out_n)) < OUT_CNT);
        mem_addr_n = base_n + issued_n;
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            for (int i = 0; i < OUT_CNT; i++) begin
                win_q[i] <= '0;
            end
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            base_q    <= base_n;
            num_q     <= num_n;
            issued_q  <= issued_n;
            retired_q <= retired_n;
            cnt_q     <= cnt_n;
            out_q     <= out_n;
            win_q     <= win_n;
            err       <= err_n;
            mem_req   <= mem_req_n;
            mem_addr  <= mem_addr_n;
            busy      <= (state_n == S_RUN);
            done      <= (state_n == S_DONE);
        end
    end

    assign arb_cnt = cnt_q;

    for (genvar g = 0; g < OUT_CNT; g++) begin : g_slot
        assign arb_clause[g*CLAUSE_W +: CLAUSE_W] = win_q[g];
    end

`ifdef CLAUSE_DISPATCH_STALL_CNT_EN
    logic [31:0] stall_q;

    // Counts RUN cycles where clauses are offered but the arbiter takes none
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (state == S_IDLE && start) begin
            stall_q <= '0;
        end else if (state == S_RUN && cnt_q != '0 && arb_accept == '0 && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_clause_dispatch_ctrl.sv
// Bench for clause_dispatch_ctrl: vector table, corner-case sequences and randomized runs against a queue model.
module tb_clause_dispatch_ctrl;
    localparam int OUT_CNT  = 4;
    localparam int CLAUSE_W = 15;
    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 3;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        start = 1'b0;
    logic [ADDR_W-1:0]           base_addr = '0;
    logic [ADDR_W-1:0]           num_clauses = '0;
    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_valid = 1'b0;
    logic [CLAUSE_W-1:0]         mem_data = '0;
    logic [OUT_CNT*CLAUSE_W-1:0] arb_clause;
    logic [CNT_W-1:0]            arb_cnt;
    logic [CNT_W-1:0]            arb_accept = '0;
    logic                        busy, done, err;
`ifdef CLAUSE_DISPATCH_STALL_CNT_EN
    logic [31:0]                 stall_cnt;
`endif

    always #5 clock = ~clock;

    clause_dispatch_ctrl #(.OUT_CNT(OUT_CNT), .CLAUSE_W(CLAUSE_W), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .num_clauses(num_clauses), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data), .arb_clause(arb_clause),
        .arb_cnt(arb_cnt), .arb_accept(arb_accept), .busy(busy), .done(done), .err(err)
`ifdef CLAUSE_DISPATCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    typedef enum int {M_IDLE, M_RUN, M_DONE} mst_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } resp_t;
    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] num;
        int                lat;
        int                mode;
        int                exp_n;
        logic [ADDR_W-1:0] exp_first;
        logic [ADDR_W-1:0] exp_last;
        logic              exp_err;
        int                exp_done;
    } vec_t;

    // Reference model: the window is a plain queue of clauses in delivery order
    mst_t                m_state = M_IDLE;
    logic [ADDR_W-1:0]   m_base = '0;
    int                  m_num = 0, m_issued = 0, m_retired = 0, m_out = 0;
    logic                m_err = 1'b0, m_req = 1'b0;
    logic [ADDR_W-1:0]   m_addr = '0;
    logic [31:0]         m_stall = '0;
    logic [CLAUSE_W-1:0] m_q[$];

    resp_t               rq[$];
    logic [ADDR_W-1:0]   alog[$];
    int                  last_due = 0, cyc = 0, lat = 1, done_seen = 0;
    bit                  hold = 0, inject = 0;
    int                  n_cmp = 0, n_bad = 0;
    vec_t                vecs[5];

    function automatic logic [CLAUSE_W-1:0] memf(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] p;
        p = a * 16'd37;
        return p[CLAUSE_W-1:0] ^ 15'h1A5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare all outputs
    task automatic tick(input int acc, input bit st, input logic [ADDR_W-1:0] sb,
                        input logic [ADDR_W-1:0] sn, input bit rst);
        bit                  v;
        logic [CLAUSE_W-1:0] d;
        resp_t               r;
        int                  a;
        v = 0;
        d = '0;
        if (!hold && rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            v = 1;
            d = memf(r.addr);
        end
        if (inject && !v) begin
            v = 1;
            d = 15'h7FFF;
        end
        inject = 0;
        reset = rst; start = st; base_addr = sb; num_clauses = sn;
        arb_accept = CNT_W'(acc); mem_valid = v; mem_data = d;
        if (m_req) begin
            r.addr = m_addr;
            r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            rq.push_back(r);
        end
        if (rst) begin
            m_state = M_IDLE; m_issued = 0; m_retired = 0; m_out = 0; m_err = 0;
            m_q.delete(); m_stall = '0; m_base = '0; m_num = 0;
        end else begin
            case (m_state)
                M_IDLE: if (st) begin
                    m_base = sb; m_num = int'(sn); m_issued = 0; m_retired = 0; m_out = 0;
                    m_err = 0; m_stall = '0;
                    m_state = (sn == 0) ? M_DONE : M_RUN;
                end
                M_RUN: begin
                    if (m_q.size() > 0 && acc == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
                    a = acc;
                    if (acc > m_q.size()) begin
                        a = m_q.size();
                        m_err = 1;
                    end
                    repeat (a) void'(m_q.pop_front());
                    m_retired += a;
                    if (v) begin
                        if (m_out > 0) begin
                            m_q.push_back(d);
                            m_out--;
                        end else begin
                            m_err = 1;
                        end
                    end
                    if (m_req) begin
                        m_issued++;
                        m_out++;
                    end
                    if (m_retired == m_num) m_state = M_DONE;
                end
                default: m_state = M_IDLE;
            endcase
        end
        m_req  = (m_state == M_RUN) && (m_issued < m_num) && (m_q.size() + m_out < OUT_CNT);
        m_addr = m_base + ADDR_W'(m_issued);
        @(posedge clock);
        #1;
        cyc++;
        reset = 0; start = 0;
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (mem_req === 1'b1) alog.push_back(mem_addr);
        chk("arb_cnt", 32'(arb_cnt), m_q.size());
        for (int i = 0; i < OUT_CNT; i++)
            chk($sformatf("slot%0d", i), 32'(arb_clause[i*CLAUSE_W +: CLAUSE_W]),
                (i < m_q.size()) ? 32'(m_q[i]) : 32'd0);
        chk("busy", 32'(busy), 32'(m_state == M_RUN));
        chk("done", 32'(done), 32'(m_state == M_DONE));
        chk("err", 32'(err), 32'(m_err));
`ifdef CLAUSE_DISPATCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (done === 1'b1) done_seen++;
    endtask

    task automatic run_to_idle(input int mode, input int budget);
        int k;
        int acc;
        k = 0;
        while (m_state != M_IDLE && k < budget) begin
            if (mode == 0) acc = m_q.size();
            else if (mode == 1) acc = $urandom_range(m_q.size(), 0);
            else acc = ($urandom_range(9, 0) == 0) ? $urandom_range(OUT_CNT, 0)
                                                   : $urandom_range(m_q.size(), 0);
            if (mode == 2) hold = ($urandom_range(3, 0) == 0);
            tick(acc, (mode == 2) && ($urandom_range(7, 0) == 0), 16'($urandom), 16'($urandom), 0);
            k++;
        end
        hold = 0;
        if (m_state != M_IDLE) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_budget: run still active after %0d cycles", budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{16'h0010, 16'd3, 1, 0, 3, 16'h0010, 16'h0012, 1'b0, 1};
        vecs[1] = '{16'hFFFF, 16'd2, 1, 0, 2, 16'hFFFF, 16'h0000, 1'b0, 1};
        vecs[2] = '{16'h1234, 16'd0, 1, 0, 0, 16'h0000, 16'h0000, 1'b0, 1};
        vecs[3] = '{16'h0100, 16'd9, 3, 1, 9, 16'h0100, 16'h0108, 1'b0, 1};
        vecs[4] = '{16'hFFFE, 16'd5, 2, 1, 5, 16'hFFFE, 16'h0002, 1'b0, 1};

        // Reset state
        tick(0, 0, '0, '0, 1);
        tick(0, 0, '0, '0, 1);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_arb_clause", 32'(arb_clause[31:0] | arb_clause[OUT_CNT*CLAUSE_W-1:32]), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);

        // Vector table
        for (int n = 0; n < 5; n++) begin
            lat = vecs[n].lat;
            alog.delete();
            done_seen = 0;
            tick(0, 1, vecs[n].base, vecs[n].num, 0);
            run_to_idle(vecs[n].mode, 300);
            chk($sformatf("vec%0d_nreq", n), alog.size(), vecs[n].exp_n);
            if (vecs[n].exp_n > 0) begin
                chk($sformatf("vec%0d_first", n), 32'(alog[0]), 32'(vecs[n].exp_first));
                chk($sformatf("vec%0d_last", n), 32'(alog[alog.size()-1]), 32'(vecs[n].exp_last));
            end
            chk($sformatf("vec%0d_err", n), 32'(err), 32'(vecs[n].exp_err));
            chk($sformatf("vec%0d_done", n), done_seen, vecs[n].exp_done);
        end

        // Arbiter stalls: window fills to 4 and reads stop
        lat = 1;
        alog.delete();
        tick(0, 1, 16'h0040, 16'd6, 0);
        repeat (10) tick(0, 0, '0, '0, 0);
        chk("stall_arb_cnt", 32'(arb_cnt), 4);
        chk("stall_issued", alog.size(), 4);
        chk("stall_req_low", 32'(mem_req), 0);
        run_to_idle(0, 100);

        // Accept 2 of A,B,C while D returns in the same cycle
        hold = 1;
        tick(0, 1, 16'h0200, 16'd4, 0);
        repeat (6) tick(0, 0, '0, '0, 0);
        hold = 0;
        repeat (3) tick(0, 0, '0, '0, 0);
        chk("abc_cnt", 32'(arb_cnt), 3);
        tick(2, 0, '0, '0, 0);
        chk("cd_slot0", 32'(arb_clause[0 +: CLAUSE_W]), 32'(memf(16'h0202)));
        chk("cd_slot1", 32'(arb_clause[CLAUSE_W +: CLAUSE_W]), 32'(memf(16'h0203)));
        chk("cd_cnt", 32'(arb_cnt), 2);
        run_to_idle(0, 100);

        // Over-accept: err sticks until the next start
        tick(0, 1, 16'h0300, 16'd1, 0);
        repeat (3) tick(0, 0, '0, '0, 0);
        chk("over_cnt_before", 32'(arb_cnt), 1);
        tick(3, 0, '0, '0, 0);
        chk("over_cnt_after", 32'(arb_cnt), 0);
        chk("over_err", 32'(err), 1);
        repeat (3) tick(0, 0, '0, '0, 0);
        chk("over_err_sticky", 32'(err), 1);
        tick(0, 1, 16'h0310, 16'd1, 0);
        chk("over_err_cleared", 32'(err), 0);
        run_to_idle(0, 100);

        // Response with nothing outstanding is dropped and flagged
        lat = 2;
        tick(0, 1, 16'h0400, 16'd2, 0);
        inject = 1;
        tick(0, 0, '0, '0, 0);
        chk("orphan_err", 32'(err), 1);
        chk("orphan_cnt", 32'(arb_cnt), 0);
        run_to_idle(0, 100);

        // Reset mid-run with reads outstanding; late responses must be ignored
        lat = 4;
        tick(0, 1, 16'h0500, 16'd6, 0);
        k = 0;
        while (m_out != 2 && k < 10) begin
            tick(0, 0, '0, '0, 0);
            k++;
        end
        chk("mid_outstanding", m_out, 2);
        tick(0, 0, '0, '0, 1);
        done_seen = 0;
        repeat (8) tick(0, 0, '0, '0, 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_cnt", 32'(arb_cnt), 0);
        chk("mid_err", 32'(err), 0);
        chk("mid_done", done_seen, 0);
        k = 0;
        while (rq.size() > 0 && k < 20) begin
            tick(0, 0, '0, '0, 0);
            k++;
        end

        // Randomized runs
        repeat (25) begin
            lat = $urandom_range(4, 1);
            tick(0, 1, 16'($urandom), 16'($urandom_range(12, 0)), 0);
            run_to_idle(2, 400);
            repeat (2) tick(0, 0, '0, '0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
